// File: rtl/matmul_sequencer_if.sv
// Operand/result streams and matrix-controller command bus for matmul_sequencer.
// master = sequencer side, slave = stream source/sink plus controller side.
interface matmul_sequencer_if;
    logic        WR_VALID;
    logic        WR_READY;
    logic [15:0] WR_DATA;

    logic        RD_VALID;
    logic        RD_READY;
    logic [15:0] RD_DATA;

    logic        CTL_EN;
    logic        CTL_WRITE;
    logic        CTL_LOAD;
    logic [2:0]  CTL_IDX;
    logic [3:0]  CTL_REG_SELECT;
    logic [15:0] CTL_DATA_IN;
    logic [15:0] CTL_DATA_OUT;

    modport master (
        input  WR_VALID, WR_DATA, RD_READY, CTL_DATA_OUT,
        output WR_READY, RD_VALID, RD_DATA,
        output CTL_EN, CTL_WRITE, CTL_LOAD, CTL_IDX, CTL_REG_SELECT, CTL_DATA_IN
    );

    modport slave (
        output WR_VALID, WR_DATA, RD_READY, CTL_DATA_OUT,
        input  WR_READY, RD_VALID, RD_DATA,
        input  CTL_EN, CTL_WRITE, CTL_LOAD, CTL_IDX, CTL_REG_SELECT, CTL_DATA_IN
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences one 8x8 matmul job: stream A/B in, load, compute, read 64 results out.
// MATSEQ_REUSE_B_EN adds REUSE_B (A-only refill). The matrix controller must share RST,
// since a reset in the middle of LOAD leaves its internal 3-bit index misaligned otherwise.
module matmul_sequencer #(
    parameter int unsigned COMPUTE_CYCLES = 24
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
`ifdef MATSEQ_REUSE_B_EN
    input  logic REUSE_B,
`endif
    output logic BUSY,
    output logic DONE,
    matmul_sequencer_if.master bus
);

    localparam int unsigned CW = (COMPUTE_CYCLES < 1) ? 1 : $clog2(COMPUTE_CYCLES + 1);
    localparam logic [CW-1:0] CmpLast = CW'((COMPUTE_CYCLES < 1) ? 0 : COMPUTE_CYCLES - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFill    = 3'd1;
    localparam logic [2:0] StLoad    = 3'd2;
    localparam logic [2:0] StCompute = 3'd3;
    localparam logic [2:0] StRdCmd   = 3'd4;
    localparam logic [2:0] StRdCap   = 3'd5;
    localparam logic [2:0] StRdOut   = 3'd6;
    localparam logic [2:0] StFin     = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [6:0]    fill_q, fill_d;
    logic [5:0]    res_q, res_d;
    logic [CW-1:0] cmp_q, cmp_d;
    logic [2:0]    load_q, load_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [6:0]    fill_last;

`ifdef MATSEQ_REUSE_B_EN
    logic reuse_q, reuse_d;
    assign fill_last = reuse_q ? 7'd63 : 7'd127;
`else
    assign fill_last = 7'd127;
`endif

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        res_d     = res_q;
        cmp_d     = cmp_q;
        load_d    = load_q;
        rd_data_d = rd_data_q;
`ifdef MATSEQ_REUSE_B_EN
        reuse_d   = reuse_q;
`endif
        bus.WR_READY       = 1'b0;
        bus.RD_VALID       = 1'b0;
        bus.CTL_EN         = 1'b0;
        bus.CTL_WRITE      = 1'b0;
        bus.CTL_LOAD       = 1'b0;
        bus.CTL_IDX        = 3'd0;
        bus.CTL_REG_SELECT = 4'd0;
        bus.CTL_DATA_IN    = 16'd0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StFill;
                    fill_d  = '0;
                    res_d   = '0;
                    cmp_d   = '0;
                    load_d  = '0;
`ifdef MATSEQ_REUSE_B_EN
                    reuse_d = REUSE_B;
`endif
                end
            end
            StFill: begin
                bus.WR_READY = 1'b1;
                // Write command goes out in the same cycle as the accepted beat.
                if (bus.WR_VALID) begin
                    bus.CTL_EN         = 1'b1;
                    bus.CTL_WRITE      = 1'b1;
                    bus.CTL_REG_SELECT = fill_q[6:3];
                    bus.CTL_IDX        = fill_q[2:0];
                    bus.CTL_DATA_IN    = bus.WR_DATA;
                    if (fill_q == fill_last) begin
                        state_d = StLoad;
                    end else begin
                        fill_d = fill_q + 7'd1;
                    end
                end
            end
            StLoad: begin
                // Eight load pulses walk the controller index a full lap back to 0.
                bus.CTL_EN   = 1'b1;
                bus.CTL_LOAD = 1'b1;
                bus.CTL_IDX  = load_q;
                if (load_q == 3'd7) begin
                    state_d = StCompute;
                end else begin
                    load_d = load_q + 3'd1;
                end
            end
            StCompute: begin
                bus.CTL_EN = 1'b1;
                if (cmp_q == CmpLast) begin
                    state_d = StRdCmd;
                    res_d   = '0;
                end else begin
                    cmp_d = cmp_q + CW'(1);
                end
            end
            StRdCmd: begin
                bus.CTL_EN         = 1'b1;
                bus.CTL_LOAD       = 1'b1;
                bus.CTL_WRITE      = 1'b1;
                bus.CTL_REG_SELECT = {1'b0, res_q[5:3]};
                bus.CTL_IDX        = res_q[2:0];
                state_d            = StRdCap;
            end
            StRdCap: begin
                rd_data_d = bus.CTL_DATA_OUT;
                state_d   = StRdOut;
            end
            StRdOut: begin
                bus.RD_VALID = 1'b1;
                if (bus.RD_READY) begin
                    if (res_q == 6'd63) begin
                        state_d = StFin;
                    end else begin
                        res_d   = res_q + 6'd1;
                        state_d = StRdCmd;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign BUSY        = (state_q != StIdle);
    assign DONE        = (state_q == StFin);
    assign bus.RD_DATA = rd_data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            fill_q    <= '0;
            res_q     <= '0;
            cmp_q     <= '0;
            load_q    <= '0;
            rd_data_q <= '0;
`ifdef MATSEQ_REUSE_B_EN
            reuse_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            res_q     <= res_d;
            cmp_q     <= cmp_d;
            load_q    <= load_d;
            rd_data_q <= rd_data_d;
`ifdef MATSEQ_REUSE_B_EN
            reuse_q   <= reuse_d;
`endif
        end
    end

endmodule
